keypad_row_scanner: RTL

KEYPAD_ROW_SCANNER -- requirements
Module: keypad_row_scanner

---
 rtl/keypad_row_scanner_pkg.sv | 44 ++++
 rtl/keypad_row_scanner_stable_timer.sv | 35 +++
 rtl/keypad_row_scanner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/keypad_row_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad row scanner.
package keypad_row_scanner_pkg;

    localparam int NUM_ROWS               = 4;
    localparam int NUM_COLS               = 4;
    localparam int DEFAULT_SCAN_TICKS     = 27_000;
    localparam int DEFAULT_DEBOUNCE_TICKS = 270_000;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_REPORT   = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    // One-hot row drive pattern for a row index.
    function automatic logic [3:0] row_onehot(input logic [1:0] row);
        logic [3:0] drive;
        case (row)
            2'd0:    drive = 4'b0001;
            2'd1:    drive = 4'b0010;
            2'd2:    drive = 4'b0100;
            2'd3:    drive = 4'b1000;
            default: drive = 4'b0001;
        endcase
        return drive;
    endfunction

    // Index of the lowest active column; several keys on one row resolve low.
    function automatic logic [1:0] lowest_col(input logic [3:0] cols);
        logic [1:0] idx;
        if (cols[0]) begin
            idx = 2'd0;
        end else if (cols[1]) begin
            idx = 2'd1;
        end else if (cols[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_scanner_stable_timer.sv
// Saturating stability counter: counts enabled cycles, flags the last one.
module stable_timer #(
    parameter int TICKS = 8,
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TICKS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);

    logic [WIDTH-1:0] cnt_r;

    // Terminal flag: the current cycle is the TICKS-th consecutive enabled one.
    assign done = (cnt_r == LAST);

    // Count enabled cycles; clear has priority and the count saturates at LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= ZERO;
        end else if (clr) begin
            cnt_r <= ZERO;
        end else if (en && !done) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/keypad_row_scanner.sv
// 4x4 keypad scanner: drives rows one-hot, debounces a press, reports the
// key code once through a valid/ready handshake, then waits for release.
module keypad_row_scanner
    import keypad_row_scanner_pkg::*;
#(
    parameter int SCAN_TICKS     = DEFAULT_SCAN_TICKS,
    parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] columnas,
    output logic [NUM_ROWS-1:0] filas,
    output logic                key_valid,
    output logic [3:0]          key_code,
    input  logic                key_ready,
    output logic                key_held
);

    localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic [3:0]       col_meta_r;
    logic [3:0]       col_sync_r;
    logic [3:0]       col_s;
    scan_state_t      state_r;
    logic [1:0]       row_r;
    logic [CNT_W-1:0] scan_cnt_r;
    logic [3:0]       pattern_r;
    logic             timer_en_s;
    logic             timer_clr_s;
    logic             timer_done_s;

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta_r <= 4'b0000;
            col_sync_r <= 4'b0000;
        end else begin
            col_meta_r <= columnas;
            col_sync_r <= col_meta_r;
        end
    end

    assign col_s = col_sync_r;

    // Stability timer runs only while the watched condition holds; it is
    // cleared in every other cycle and on its terminal cycle, so each state
    // entry starts from zero.
    always_comb begin
        timer_en_s = 1'b0;
        case (state_r)
            ST_DEBOUNCE: timer_en_s = (col_s == pattern_r);
            ST_RELEASE:  timer_en_s = (col_s == 4'b0000);
            default:     timer_en_s = 1'b0;
        endcase
        timer_clr_s = !timer_en_s || timer_done_s;
    end

    stable_timer #(
        .TICKS (DEBOUNCE_TICKS),
        .WIDTH (CNT_W)
    ) u_stable_timer (
        .clk   (clk),
        .reset (reset),
        .en    (timer_en_s),
        .clr   (timer_clr_s),
        .done  (timer_done_s)
    );

    // Scan/debounce/report/release state machine with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_SCAN;
            row_r      <= 2'd0;
            scan_cnt_r <= CNT_ZERO;
            pattern_r  <= 4'b0000;
            filas      <= 4'b0001;
            key_valid  <= 1'b0;
            key_code   <= 4'h0;
            key_held   <= 1'b0;
        end else begin
            case (state_r)
                ST_SCAN: begin
                    if (scan_cnt_r == SCAN_LAST) begin
                        scan_cnt_r <= CNT_ZERO;
                        if (col_s == 4'b0000) begin
                            row_r <= row_r + 2'd1;
                            filas <= row_onehot(row_r + 2'd1);
                        end else begin
                            pattern_r <= col_s;
                            state_r   <= ST_DEBOUNCE;
                        end
                    end else begin
                        scan_cnt_r <= scan_cnt_r + CNT_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s != pattern_r) begin
                        // Bounce: rescan the same row from a fresh count.
                        scan_cnt_r <= CNT_ZERO;
                        state_r    <= ST_SCAN;
                    end else if (timer_done_s) begin
                        key_code  <= {row_r, lowest_col(pattern_r)};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state_r   <= ST_REPORT;
                    end else begin
                        state_r <= ST_DEBOUNCE;
                    end
                end
                ST_REPORT: begin
                    // Releasing the key here does not withdraw the code.
                    if (key_ready) begin
                        key_valid <= 1'b0;
                        state_r   <= ST_RELEASE;
                    end else begin
                        state_r <= ST_REPORT;
                    end
                end
                ST_RELEASE: begin
                    if ((col_s == 4'b0000) && timer_done_s) begin
                        row_r      <= row_r + 2'd1;
                        filas      <= row_onehot(row_r + 2'd1);
                        key_held   <= 1'b0;
                        scan_cnt_r <= CNT_ZERO;
                        state_r    <= ST_SCAN;
                    end else begin
                        state_r <= ST_RELEASE;
                    end
                end
                default: begin
                    state_r    <= ST_SCAN;
                    row_r      <= 2'd0;
                    scan_cnt_r <= CNT_ZERO;
                    filas      <= 4'b0001;
                    key_valid  <= 1'b0;
                    key_held   <= 1'b0;
                end
            endcase
        end
    end

endmodule
